// File: rtl/shift_sched_4b_pkg.sv
// Shared definitions for the two-requester shift scheduler.
//   state_e    : scheduler FSM states (IDLE, SHIFT, DONE)
//   SHIFT_LEFT : direction code 0, SHIFT_RIGHT : direction code 1
//   pack_ctrl  : packs {dir, step, fill} into the 4-bit shifter control word
package shift_sched_4b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  // Control word layout: [3] direction, [2:1] step amount, [0] fill bit.
  function automatic logic [3:0] pack_ctrl(input logic       dir,
                                           input logic [1:0] step,
                                           input logic       fill);
    return {dir, step, fill};
  endfunction

endpackage

// File: rtl/shifter_4b.sv
// Combinational 4-bit shifter, 0..3 positions per use.
//   a : value to shift
//   b : control {dir, amount[1:0], fill}
//   x : shifted value, vacated positions take the fill bit
//   y : bits shifted out, right-aligned, zero-padded
module shifter_4b
  import shift_sched_4b_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] x,
  output logic [3:0] y
);

  logic       dir;
  logic [1:0] amt;
  logic       fill;
  logic [3:0] low_mask;
  logic [3:0] high_mask;
  logic [7:0] wide;

  // NOTE: every signal written in this always_comb gets a default first, so
  // no path through the branches leaves one unassigned and infers a latch.
  always_comb begin
    dir       = b[3];
    amt       = b[2:1];
    fill      = b[0];
    low_mask  = (4'b0001 << amt) - 4'b0001;  // amt ones at the bottom
    high_mask = ~(4'b1111 >> amt);            // amt ones at the top
    wide      = '0;
    x         = '0;
    y         = '0;
    if (dir == SHIFT_LEFT) begin
      // Bits pushed past bit 3 land in the upper nibble, already right-aligned.
      wide = {4'b0000, a} << amt;
      x    = wide[3:0] | (fill ? low_mask : 4'b0000);
      y    = wide[7:4];
    end else begin
      x = (a >> amt) | (fill ? high_mask : 4'b0000);
      y = a & low_mask;
    end
  end

endmodule

// File: rtl/shift_sched_4b.sv
// Two-requester round-robin scheduler around one shared shifter_4b, extending
// it to shifts of 0..15 positions by iterating at most MAX_STEP per cycle.
//   clk, rst             : clock, asynchronous active-high reset
//   req_valid/req_ready  : per-requester handshake (bit i = requester i)
//   a*/amt*/dir*/fill*   : per-requester operands, sampled at acceptance
//   res_valid            : one-hot, one-cycle completion pulse
//   res_x / res_sticky   : result and OR of all shifted-out bits
//   busy                 : high while an operation is in SHIFT or DONE
module shift_sched_4b
  import shift_sched_4b_pkg::*;
#(
  parameter int unsigned MAX_STEP = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] amt0,
  input  logic [3:0] amt1,
  input  logic       dir0,
  input  logic       dir1,
  input  logic       fill0,
  input  logic       fill1,
  output logic [1:0] res_valid,
  output logic [3:0] res_x,
  output logic       res_sticky,
  output logic       busy
);

  localparam logic [3:0] STEP_CAP = 4'(MAX_STEP);

  state_e     state_q, state_d;
  logic [3:0] value_q, value_d;
  logic [3:0] rem_q, rem_d;
  logic       dir_q, dir_d;
  logic       fill_q, fill_d;
  logic       owner_q, owner_d;
  logic       sticky_q, sticky_d;
  logic       last_q, last_d;
  logic [3:0] res_x_q, res_x_d;
  logic       res_sticky_q, res_sticky_d;

  logic [1:0] grant;
  logic       sel;
  logic [1:0] step;
  logic [3:0] sh_x, sh_y;
  logic [3:0] rem_next;
  logic       sticky_next;
  logic [3:0] sel_amt;

  shifter_4b u_shifter (
    .a (value_q),
    .b (pack_ctrl(dir_q, step, fill_q)),
    .x (sh_x),
    .y (sh_y)
  );

  // Round-robin: a tie goes to the requester that was not served last.
  always_comb begin
    if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
    else                    grant = req_valid;
    sel = grant[1];
  end

  always_comb begin
    step        = (rem_q < STEP_CAP) ? rem_q[1:0] : STEP_CAP[1:0];
    rem_next    = rem_q - {2'b00, step};
    sticky_next = sticky_q | (sh_y != 4'b0000);
    sel_amt     = sel ? amt1 : amt0;
  end

  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    rem_d        = rem_q;
    dir_d        = dir_q;
    fill_d       = fill_q;
    owner_d      = owner_q;
    sticky_d     = sticky_q;
    last_d       = last_q;
    res_x_d      = res_x_q;
    res_sticky_d = res_sticky_q;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          value_d  = sel ? a1 : a0;
          rem_d    = sel_amt;
          dir_d    = sel ? dir1 : dir0;
          fill_d   = sel ? fill1 : fill0;
          owner_d  = sel;
          last_d   = sel;
          sticky_d = 1'b0;
          if (sel_amt == 4'd0) begin
            // Zero-length shift: result is the operand itself, nothing lost.
            state_d      = DONE;
            res_x_d      = sel ? a1 : a0;
            res_sticky_d = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        value_d  = sh_x;
        sticky_d = sticky_next;
        rem_d    = rem_next;
        if (rem_next == 4'd0) begin
          // Result registers load on entry to DONE and then hold until the
          // next completion, so they stay stable outside the pulse.
          state_d      = DONE;
          res_x_d      = sh_x;
          res_sticky_d = sticky_next;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      value_q      <= '0;
      rem_q        <= '0;
      dir_q        <= SHIFT_LEFT;
      fill_q       <= 1'b0;
      owner_q      <= 1'b0;
      sticky_q     <= 1'b0;
      last_q       <= 1'b1;
      res_x_q      <= '0;
      res_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      rem_q        <= rem_d;
      dir_q        <= dir_d;
      fill_q       <= fill_d;
      owner_q      <= owner_d;
      sticky_q     <= sticky_d;
      last_q       <= last_d;
      res_x_q      <= res_x_d;
      res_sticky_q <= res_sticky_d;
    end
  end

  // Ready is masked during reset so nothing appears accepted while held.
  assign req_ready  = (state_q == IDLE && !rst) ? grant : 2'b00;
  assign res_valid  = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign res_x      = res_x_q;
  assign res_sticky = res_sticky_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/shift_sched_4b.md
# shift_sched_4b

Two-requester scheduler that shares one `shifter_4b` instance and extends it to multi-cycle shifts of 0–15 positions. It has the following responsibilities:
- arbitrate round-robin between two requesters;
- decompose each shift amount into shifter steps of at most `MAX_STEP` positions and iterate the shifter one step per cycle;
- accumulate a sticky flag over all shifted-out bits;
- return the result to the granted requester with a one-cycle completion pulse.

It sits between client datapath blocks and the shared shifter.

## Interface
- `MAX_STEP`, 3, largest shift issued to `shifter_4b` per cycle; legal 1..3.

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `req_valid`  in  2  request valid, bit i = requester i
- `req_ready`  out  2  request accepted when `req_valid[i] & req_ready[i]`
- `a0`, `a1`  in  4  value to shift, per requester
- `amt0`, `amt1`  in  4  total shift amount 0..15
- `dir0`, `dir1`  in  1  0 = left, 1 = right
- `fill0`, `fill1`  in  1  bit shifted in
- `res_valid`  out  2  one-hot, one-cycle completion pulse to requester i
- `res_x`  out  4  shifted result, valid while `res_valid != 0`
- `res_sticky`  out  1  OR of every bit shifted out over the whole operation
- `busy`  out  1  high in SHIFT and DONE

## Operation
- `shifter_4b` control word is `B = {dir, step[1:0], fill}`: `B[3]` = direction, `B[2:1]` = amount, `B[0]` = fill.
- Outputs: `X` = shifted value; `Y` = bits shifted out, right-aligned, zero-padded.
- States:
  - **IDLE**: `req_ready` = grant vector, at most one bit set. Acceptance latches `value`, `remaining = amt`, `dir`, `fill`, and the owner index. `sticky` clears to 0. Next state is SHIFT if `amt != 0`, else DONE.
  - **SHIFT**: `step = min(remaining, MAX_STEP)`. The block drives the shifter with `A = value` and issues `step`. On the edge: `value <= X`, `sticky <= sticky | (Y != 0)`, `remaining <= remaining - step`. It goes to DONE when `remaining - step == 0`, otherwise it stays in SHIFT.
  - **DONE**: `res_valid[owner] = 1`, `res_x = value`, `res_sticky = sticky`. Unconditionally returns to IDLE. No backpressure on results.
- Arbitration:
  - A `last` pointer flips to the owner on each grant.
  - With both requests valid, grant `~last`. With one valid, grant it.
  - After reset `last = 1`, so requester 0 wins the first tie.
- `req_ready = 0` outside IDLE. Requests are held by the requester until accepted; inputs are sampled only at acceptance.
- Amounts ≥ 4 saturate the value to all-`fill` but still take the full `ceil(amt/MAX_STEP)` cycles. The sticky flag reflects every bit shifted out.
- `remaining` is 4 bits wide. A subtraction never underflows because `step ≤ remaining`.

## Timing
- Acceptance at edge t: `res_valid` is high during cycle t+1+ceil(amt/MAX_STEP).
  - With `MAX_STEP=3`: amt 0 → t+1; amt 1..3 → t+2; amt 15 → t+6.
- Next acceptance is possible in the cycle after DONE, so there is one IDLE cycle minimum between operations.
- Reset values: state IDLE, `req_ready` 00 (becomes combinationally the grant in IDLE once `rst` falls), `res_valid` 00, `res_x` 0000, `res_sticky` 0, `busy` 0, `last` 1.
- Reset mid-operation aborts immediately. No `res_valid` is produced for the aborted request; the requester must reissue.
- `res_x` and `res_sticky` hold their last DONE values outside DONE. Benches must check them only with `res_valid`.

## Structure
- The shared package holds:
  - state enum `{IDLE, SHIFT, DONE}`;
  - `SHIFT_LEFT=0`, `SHIFT_RIGHT=1`;
  - a function packing `{dir, step, fill}` into the 4-bit shifter control.
- One sub-module: the existing `shifter_4b`, instantiated once.
- The arbiter is inline logic; no separate module.

## Test plan
- Req0 `a=0111`, `amt=1`, left, fill 0 → `res_valid=01` at t+2, `res_x=1110`, `res_sticky=0`.
- Req1 `a=0111`, `amt=5`, left, fill 0 → steps 3 then 2. Response: `res_valid=10` at t+3, `res_x=0000`, `res_sticky=1`.
- Req0 `a=0111`, `amt=1`, right, fill 1 → `res_x=1011`, `res_sticky=1`. Req0 `a=1010`, `amt=0` → `res_x=1010`, `res_sticky=0`, `res_valid` at t+1.
- Both valid in the first cycle after reset, each `amt=3` → req0 is served first (done at t+2). Req1 is accepted at the next IDLE. Then both are re-asserted → req1 is no longer favored: `last=1` gives req0 the next grant.
- `rst` asserted during SHIFT of an `amt=15` request → all outputs return to reset values asynchronously. No `res_valid` is seen, and a new request is accepted normally after release.
